// File: rtl/eth_rx_frame_ctl_if.sv
// ============================================================================
// eth_rx_frame_ctl_if : receive frame controller bus (PHY strobes, page status, CPU ack)
// Revision 1.0
// ============================================================================
`default_nettype none

interface eth_rx_frame_ctl_if;
  logic        n_ss;
  logic        n_inhibit;
  logic        n_recv_buf_we;
  logic        buf_page;
  logic        rx_ready;
  logic        rx_page;
  logic [10:0] rx_len;
  logic        cpu_ack;
  logic [7:0]  drop_cnt;

  modport master (
    output n_ss, n_inhibit, n_recv_buf_we, cpu_ack,
    input  buf_page, rx_ready, rx_page, rx_len, drop_cnt
  );

  modport slave (
    input  n_ss, n_inhibit, n_recv_buf_we, cpu_ack,
    output buf_page, rx_ready, rx_page, rx_len, drop_cnt
  );
endinterface

`default_nettype wire

// File: rtl/eth_rx_frame_ctl.sv
// ============================================================================
// eth_rx_frame_ctl : ping-pong receive page manager with frame length/filter drop
// Revision 1.0
// ============================================================================
`default_nettype none

module eth_rx_frame_ctl #(
  parameter int MIN_LEN = 14,
  parameter int MAX_LEN = 1536
) (
  input  logic                 clk,
  input  logic                 n_rst,
  eth_rx_frame_ctl_if.slave    bus
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_RECV   = 2'd1;
  localparam logic [1:0]  ST_DROP   = 2'd2;
  localparam logic [1:0]  ST_COMMIT = 2'd3;

  localparam logic [10:0] C_CNT_MAX = 11'd2047;
  localparam logic [10:0] C_MIN_LEN = 11'(MIN_LEN);
  localparam logic [10:0] C_MAX_LEN = 11'(MAX_LEN);
  localparam logic [7:0]  C_DROP_MAX = 8'hFF;

  logic        ss_meta_q, ss_sync_q, ss_prev_q;
  logic        inh_meta_q, inh_sync_q;
  logic        we_meta_q, we_sync_q, we_prev_q;

  logic [1:0]  state_q, state_d;
  logic [10:0] count_q, count_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic [1:0]  full_q, full_d;
  logic        buf_page_q, buf_page_d;
  logic        rx_page_q, rx_page_d;
  logic [10:0] len0_q, len0_d;
  logic [10:0] len1_q, len1_d;

  logic        ss_fall, ss_rise, we_rise, len_ok;

  // Synchronisers reset to the inactive (high) level so release never fakes an edge
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ss_meta_q  <= 1'b1;
      ss_sync_q  <= 1'b1;
      ss_prev_q  <= 1'b1;
      inh_meta_q <= 1'b1;
      inh_sync_q <= 1'b1;
      we_meta_q  <= 1'b1;
      we_sync_q  <= 1'b1;
      we_prev_q  <= 1'b1;
    end else begin
      ss_meta_q  <= bus.n_ss;
      ss_sync_q  <= ss_meta_q;
      ss_prev_q  <= ss_sync_q;
      inh_meta_q <= bus.n_inhibit;
      inh_sync_q <= inh_meta_q;
      we_meta_q  <= bus.n_recv_buf_we;
      we_sync_q  <= we_meta_q;
      we_prev_q  <= we_sync_q;
    end
  end

  assign ss_fall = ss_prev_q & ~ss_sync_q;
  assign ss_rise = ~ss_prev_q & ss_sync_q;
  assign we_rise = ~we_prev_q & we_sync_q;
  assign len_ok  = (count_q >= C_MIN_LEN) && (count_q <= C_MAX_LEN);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    full_d     = full_q;
    buf_page_d = buf_page_q;
    rx_page_d  = rx_page_q;
    len0_d     = len0_q;
    len1_d     = len1_q;

    if (we_rise && (count_q != C_CNT_MAX)) begin
      count_d = count_q + 11'd1;
    end

    // The ack is applied before any commit in the same cycle so neither is lost
    if (bus.cpu_ack && (|full_q)) begin
      full_d[rx_page_q] = 1'b0;
      if (full_q[~rx_page_q]) begin
        rx_page_d = ~rx_page_q;
      end
      if (&full_q) begin
        buf_page_d = rx_page_q;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          if (!(&full_q)) begin
            state_d = ST_RECV;
            count_d = '0;
          end else begin
            state_d = ST_DROP;
            if (drop_cnt_q != C_DROP_MAX) begin
              drop_cnt_d = drop_cnt_q + 8'd1;
            end
          end
        end
      end
      ST_RECV: begin
        if (ss_rise) begin
          state_d = ST_COMMIT;
        end else if (!inh_sync_q) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (len_ok) begin
          full_d[buf_page_q] = 1'b1;
          if (buf_page_q) begin
            len1_d = count_q;
          end else begin
            len0_d = count_q;
          end
          // Other page empty: this frame is now the oldest, and the receiver moves on
          if (!full_d[~buf_page_q]) begin
            buf_page_d = ~buf_page_q;
            rx_page_d  = buf_page_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      drop_cnt_q <= '0;
      full_q     <= '0;
      buf_page_q <= 1'b0;
      rx_page_q  <= 1'b0;
      len0_q     <= '0;
      len1_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      full_q     <= full_d;
      buf_page_q <= buf_page_d;
      rx_page_q  <= rx_page_d;
      len0_q     <= len0_d;
      len1_q     <= len1_d;
    end
  end

  assign bus.buf_page = buf_page_q;
  assign bus.rx_ready = |full_q;
  assign bus.rx_page  = rx_page_q;
  assign bus.rx_len   = rx_page_q ? len1_q : len0_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_eth_rx_frame_ctl.sv
// ============================================================================
// tb_eth_rx_frame_ctl : scoreboard bench for the receive page manager
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_eth_rx_frame_ctl;

  typedef struct {
    int page;
    int len;
  } exp_t;

  logic clk;
  logic n_rst;
  int   n_chk;
  int   n_pass;
  exp_t exp_q[$];

  eth_rx_frame_ctl_if bus_if();

  eth_rx_frame_ctl #(
    .MIN_LEN (14),
    .MAX_LEN (1536)
  ) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, ".rx_ready"}, int'(bus_if.rx_ready), 0);
    end else begin
      chk({tag, ".rx_ready"}, int'(bus_if.rx_ready), 1);
      chk({tag, ".rx_page"},  int'(bus_if.rx_page),  exp_q[0].page);
      chk({tag, ".rx_len"},   int'(bus_if.rx_len),   exp_q[0].len);
    end
  endtask

  task automatic do_reset();
    n_rst                = 1'b0;
    bus_if.n_ss          = 1'b1;
    bus_if.n_inhibit     = 1'b1;
    bus_if.n_recv_buf_we = 1'b1;
    bus_if.cpu_ack       = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // inh_after < 0 keeps the filter passive; ack_commit pulses cpu_ack in the COMMIT cycle
  task automatic send_frame(input int nbytes, input int inh_after, input bit ack_commit);
    bus_if.n_ss = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbytes; i++) begin
      bus_if.n_recv_buf_we = 1'b0;
      repeat (3) @(negedge clk);
      bus_if.n_recv_buf_we = 1'b1;
      repeat (3) @(negedge clk);
      if (i + 1 == inh_after) bus_if.n_inhibit = 1'b0;
    end
    repeat (2) @(negedge clk);
    bus_if.n_ss = 1'b1;
    repeat (3) @(negedge clk);
    if (ack_commit) begin
      bus_if.cpu_ack = 1'b1;
      @(negedge clk);
      bus_if.cpu_ack = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    bus_if.n_inhibit = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_ack(input string tag);
    bus_if.cpu_ack = 1'b1;
    @(negedge clk);
    bus_if.cpu_ack = 1'b0;
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    check_head(tag);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;

    do_reset();
    chk("rst.rx_ready", int'(bus_if.rx_ready), 0);
    chk("rst.rx_page",  int'(bus_if.rx_page),  0);
    chk("rst.rx_len",   int'(bus_if.rx_len),   0);
    chk("rst.buf_page", int'(bus_if.buf_page), 0);
    chk("rst.drop_cnt", int'(bus_if.drop_cnt), 0);

    // Single valid frame
    send_frame(20, -1, 1'b0);
    exp_q.push_back('{page: 0, len: 20});
    check_head("t1");
    chk("t1.buf_page", int'(bus_if.buf_page), 1);

    // Filter reject mid-frame
    do_reset();
    send_frame(20, 6, 1'b0);
    check_head("t2");
    chk("t2.buf_page", int'(bus_if.buf_page), 0);
    chk("t2.drop_cnt", int'(bus_if.drop_cnt), 0);

    // Runt and oversize, then both length limits exactly
    do_reset();
    send_frame(10, -1, 1'b0);
    check_head("t3.runt");
    send_frame(1600, -1, 1'b0);
    check_head("t3.big");
    chk("t3.buf_page", int'(bus_if.buf_page), 0);
    send_frame(14, -1, 1'b0);
    exp_q.push_back('{page: 0, len: 14});
    check_head("t3.min");
    do_ack("t3.ack");
    send_frame(1536, -1, 1'b0);
    exp_q.push_back('{page: 1, len: 1536});
    check_head("t3.max");

    // Both pages full, third frame dropped, drain in order
    do_reset();
    send_frame(20, -1, 1'b0);
    exp_q.push_back('{page: 0, len: 20});
    send_frame(30, -1, 1'b0);
    exp_q.push_back('{page: 1, len: 30});
    check_head("t4.two");
    chk("t4.buf_page_full", int'(bus_if.buf_page), 1);
    send_frame(40, -1, 1'b0);
    check_head("t4.drop");
    chk("t4.drop_cnt", int'(bus_if.drop_cnt), 1);
    do_ack("t4.ack1");
    chk("t4.buf_page_freed", int'(bus_if.buf_page), 0);
    do_ack("t4.ack2");
    bus_if.cpu_ack = 1'b1;
    @(negedge clk);
    bus_if.cpu_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_head("t4.idle_ack");
    chk("t4.idle_ack.buf_page", int'(bus_if.buf_page), 0);
    chk("t4.idle_ack.drop_cnt", int'(bus_if.drop_cnt), 1);
    send_frame(25, -1, 1'b0);
    exp_q.push_back('{page: 0, len: 25});
    check_head("t4.refill");
    chk("t4.refill.buf_page", int'(bus_if.buf_page), 1);

    // Ack coinciding with the commit of the second frame
    do_reset();
    send_frame(20, -1, 1'b0);
    exp_q.push_back('{page: 0, len: 20});
    exp_q.push_back('{page: 1, len: 30});
    send_frame(30, -1, 1'b1);
    check_head("t5");
    chk("t5.buf_page", int'(bus_if.buf_page), 0);
    chk("t5.queue_depth", exp_q.size(), 1);

    // Async reset mid-frame with one page full
    do_reset();
    send_frame(20, -1, 1'b0);
    exp_q.push_back('{page: 0, len: 20});
    check_head("t6.pre");
    bus_if.n_ss = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus_if.n_recv_buf_we = 1'b0;
      repeat (3) @(negedge clk);
      bus_if.n_recv_buf_we = 1'b1;
      repeat (3) @(negedge clk);
    end
    n_rst = 1'b0;
    #1;
    exp_q.delete();
    chk("t6.rst.rx_ready", int'(bus_if.rx_ready), 0);
    chk("t6.rst.rx_page",  int'(bus_if.rx_page),  0);
    chk("t6.rst.rx_len",   int'(bus_if.rx_len),   0);
    chk("t6.rst.buf_page", int'(bus_if.buf_page), 0);
    chk("t6.rst.drop_cnt", int'(bus_if.drop_cnt), 0);
    bus_if.n_ss = 1'b1;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(25, -1, 1'b0);
    exp_q.push_back('{page: 0, len: 25});
    check_head("t6.post");
    chk("t6.post.buf_page", int'(bus_if.buf_page), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
